// File: rtl/xmit_prio_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | xmit_prio_scheduler_if                                                 |
// | Ingress queue, data FIFO and downstream byte bus of the TX scheduler.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface xmit_prio_scheduler_if #(
    parameter int LEN_W = 12
);
    logic             hi_frame_avail;
    logic [LEN_W-1:0] hi_frame_len;
    logic             lo_frame_avail;
    logic [LEN_W-1:0] lo_frame_len;
    logic             hi_ctrl_pop;
    logic             lo_ctrl_pop;
    logic             hi_data_rd;
    logic             lo_data_rd;
    logic [7:0]       hi_data_in;
    logic [7:0]       lo_data_in;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             tx_data_valid;
    logic             tx_sof;
    logic             tx_eof;
    logic             m_discard_en;
    logic             cur_is_hi;
    logic             sched_busy;

    modport master (
        input  hi_frame_avail, hi_frame_len, lo_frame_avail, lo_frame_len,
        input  hi_data_in, lo_data_in, tx_ready,
        output hi_ctrl_pop, lo_ctrl_pop, hi_data_rd, lo_data_rd,
        output tx_data, tx_data_valid, tx_sof, tx_eof,
        output m_discard_en, cur_is_hi, sched_busy
    );

    modport slave (
        output hi_frame_avail, hi_frame_len, lo_frame_avail, lo_frame_len,
        output hi_data_in, lo_data_in, tx_ready,
        input  hi_ctrl_pop, lo_ctrl_pop, hi_data_rd, lo_data_rd,
        input  tx_data, tx_data_valid, tx_sof, tx_eof,
        input  m_discard_en, cur_is_hi, sched_busy
    );
endinterface
`default_nettype wire

// File: rtl/xmit_prio_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | xmit_prio_scheduler                                                    |
// | Hi/lo frame scheduler: strict priority with starvation guard, length   |
// | discard and byte streaming. XMIT_STRICT_PRIO_EN drops the guard.       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module xmit_prio_scheduler #(
    parameter int LEN_W        = 12,
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518,
    parameter int MAX_HI_BURST = 4,
    parameter int IFG_CYCLES   = 12
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    xmit_prio_scheduler_if.master bus
);
    localparam int               c_GAP_W    = $clog2(IFG_CYCLES + 1);
    localparam logic [LEN_W-1:0] c_MIN      = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] c_MAX      = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_ONE      = LEN_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_INIT = c_GAP_W'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_XFER    = 3'd2,
        S_DISCARD = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   rem_q;
    logic [c_GAP_W-1:0] gap_q;
    logic               cur_hi_q;
    logic               first_q;
    logic               p1_vld_q;
    logic               p1_sof_q;
    logic               p1_eof_q;
    logic               p1_hi_q;
    logic [7:0]         tx_data_q;
    logic               tx_vld_q;
    logic               tx_sof_q;
    logic               tx_eof_q;

    logic               any_avail_d;
    logic               sel_hi_d;
    logic [LEN_W-1:0]   len_d;
    logic               len_ok_d;
    logic               rd_en_d;

    assign any_avail_d = bus.hi_frame_avail | bus.lo_frame_avail;

`ifdef XMIT_STRICT_PRIO_EN
    assign sel_hi_d = bus.hi_frame_avail;
`else
    localparam int                 c_BURST_W   = $clog2(MAX_HI_BURST + 1);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(MAX_HI_BURST);

    logic [c_BURST_W-1:0] burst_q;

    // Hi keeps winning until it has taken MAX_HI_BURST frames in a row over a waiting lo.
    assign sel_hi_d = bus.hi_frame_avail & (~bus.lo_frame_avail | (burst_q < c_BURST_MAX));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            burst_q <= '0;
        end else if (state_q == S_ARB && any_avail_d) begin
            if (sel_hi_d && bus.lo_frame_avail) begin
                if (burst_q != c_BURST_MAX) begin
                    burst_q <= burst_q + 1'b1;
                end
            end else begin
                burst_q <= '0;
            end
        end
    end
`endif

    assign len_d    = sel_hi_d ? bus.hi_frame_len : bus.lo_frame_len;
    assign len_ok_d = (len_d >= c_MIN) && (len_d <= c_MAX);

    // Discards drain the data FIFO regardless of downstream backpressure.
    always_comb begin
        rd_en_d = 1'b0;
        case (state_q)
            S_XFER:    rd_en_d = bus.tx_ready && (rem_q != '0);
            S_DISCARD: rd_en_d = (rem_q != '0);
            default:   rd_en_d = 1'b0;
        endcase
    end

    assign bus.hi_ctrl_pop   = (state_q == S_ARB) & any_avail_d & sel_hi_d;
    assign bus.lo_ctrl_pop   = (state_q == S_ARB) & any_avail_d & ~sel_hi_d;
    assign bus.hi_data_rd    = rd_en_d & cur_hi_q;
    assign bus.lo_data_rd    = rd_en_d & ~cur_hi_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_data_valid = tx_vld_q;
    assign bus.tx_sof        = tx_sof_q;
    assign bus.tx_eof        = tx_eof_q;
    assign bus.m_discard_en  = (state_q == S_DISCARD);
    assign bus.cur_is_hi     = cur_hi_q;
    assign bus.sched_busy    = (state_q != S_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            gap_q     <= '0;
            cur_hi_q  <= 1'b0;
            first_q   <= 1'b0;
            p1_vld_q  <= 1'b0;
            p1_sof_q  <= 1'b0;
            p1_eof_q  <= 1'b0;
            p1_hi_q   <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            tx_sof_q  <= 1'b0;
            tx_eof_q  <= 1'b0;
        end else begin
            // Stage 1 tracks the read issued this cycle; stage 2 captures the FIFO output.
            p1_vld_q <= rd_en_d && (state_q == S_XFER);
            p1_sof_q <= first_q;
            p1_eof_q <= (rem_q == c_ONE);
            p1_hi_q  <= cur_hi_q;
            tx_vld_q <= p1_vld_q;
            tx_sof_q <= p1_vld_q & p1_sof_q;
            tx_eof_q <= p1_vld_q & p1_eof_q;
            if (p1_vld_q) begin
                tx_data_q <= p1_hi_q ? bus.hi_data_in : bus.lo_data_in;
            end

            case (state_q)
                S_IDLE: begin
                    if (any_avail_d) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (any_avail_d) begin
                        rem_q    <= len_d;
                        cur_hi_q <= sel_hi_d;
                        first_q  <= 1'b1;
                        state_q  <= len_ok_d ? S_XFER : S_DISCARD;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_XFER: begin
                    if (rd_en_d) begin
                        rem_q   <= rem_q - c_ONE;
                        first_q <= 1'b0;
                        if (rem_q == c_ONE) begin
                            gap_q   <= c_GAP_INIT;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_DISCARD: begin
                    if (rem_q != '0) begin
                        rem_q <= rem_q - c_ONE;
                    end
                    if (rem_q <= c_ONE) begin
                        state_q <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
